// File: rtl/freq_divider_bank_if.sv
// Bus bundle for freq_divider_bank: enables, shared config write port and divided outputs.
// Define FREQDIV_PULSE_MODE_EN to add the config_mode bit written alongside each divisor.
interface freq_divider_bank_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  // config_div is a one-cycle qualifier: every cycle it is high is exactly one
  // write of din (and config_mode) into channel config_sel. There is no ready;
  // the bank always accepts, and selects >= NCH are silently dropped.
  logic [NCH-1:0]   enable;
  logic             config_div;
  logic [SELW-1:0]  config_sel;
  logic [WIDTH-1:0] din;
`ifdef FREQDIV_PULSE_MODE_EN
  logic             config_mode;
`endif
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

`ifdef FREQDIV_PULSE_MODE_EN
  modport master (
    output enable, config_div, config_sel, din, config_mode,
    input  clk_out, tick
  );
  modport slave (
    input  enable, config_div, config_sel, din, config_mode,
    output clk_out, tick
  );
`else
  modport master (
    output enable, config_div, config_sel, din,
    input  clk_out, tick
  );
  modport slave (
    input  enable, config_div, config_sel, din,
    output clk_out, tick
  );
`endif
endinterface

// File: rtl/freq_divider_bank.sv
// N-channel programmable clock divider with per-channel enable and glitch-free divisor reload.
// Optional FREQDIV_PULSE_MODE_EN adds a per-channel pulse/toggle output mode bit.
module freq_divider_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  freq_divider_bank_if.slave   bus
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act_div;
    logic [WIDTH-1:0] shd_div;
    logic             out_q;
    logic             tick_q;
    logic             wr;
    logic             tc;
`ifdef FREQDIV_PULSE_MODE_EN
    logic             act_mode;
    logic             shd_mode;
`endif

    // Selects outside 0..NCH-1 match no channel, so such writes vanish.
    assign wr = bus.config_div && (bus.config_sel == SELW'(c));
    assign tc = bus.enable[c] && (cnt == act_div);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt      <= '0;
        act_div  <= '0;
        shd_div  <= '0;
        out_q    <= 1'b0;
        tick_q   <= 1'b0;
`ifdef FREQDIV_PULSE_MODE_EN
        act_mode <= 1'b0;
        shd_mode <= 1'b0;
`endif
      end else if (!bus.enable[c]) begin
        cnt    <= '0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
        // An idle channel has no period in flight, so a write takes effect now.
        if (wr) begin
          shd_div  <= bus.din;
          act_div  <= bus.din;
`ifdef FREQDIV_PULSE_MODE_EN
          shd_mode <= bus.config_mode;
          act_mode <= bus.config_mode;
`endif
        end
      end else begin
        if (wr) begin
          shd_div  <= bus.din;
`ifdef FREQDIV_PULSE_MODE_EN
          shd_mode <= bus.config_mode;
`endif
        end
        if (tc) begin
          // Active settings swap only here, so the running period never shortens;
          // a write on this same edge lands in the shadow for the period after.
          cnt     <= '0;
          tick_q  <= 1'b1;
          act_div <= shd_div;
`ifdef FREQDIV_PULSE_MODE_EN
          act_mode <= shd_mode;
          out_q    <= shd_mode ? 1'b1 : ~out_q;
`else
          out_q    <= ~out_q;
`endif
        end else begin
          cnt    <= cnt + WIDTH'(1);
          tick_q <= 1'b0;
`ifdef FREQDIV_PULSE_MODE_EN
          if (act_mode) out_q <= 1'b0;
`endif
        end
      end
    end

    assign bus.clk_out[c] = out_q;
    assign bus.tick[c]    = tick_q;
  end

endmodule
